spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the rate count and ISI count outputs.
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port ena  input  1  decoder enable; low forces IDLE.
REQ-005 Port spike  input  1  spike level from the neuron, synchronous to clk.
REQ-006 Port win_sel  input  2  window length select: 0/1/2/3 selects 16/32/64/128 cycles.
REQ-007 Port clear  input  1  synchronous restart of the current window.
REQ-008 Port rate  output  CNT_W  spike count of the last completed window.
REQ-009 Port rate_valid  output  1  one-cycle pulse when rate updates.
REQ-010 Port isi  output  CNT_W  inter-spike interval in cycles.
REQ-011 Port isi_valid  output  1  one-cycle pulse when isi updates.
REQ-012 Port busy  output  1  high while in COUNT.

Function
REQ-013 A spike event SHALL be a rising edge of spike: spike=1 this cycle and the registered previous spike=0; a level held high SHALL count once.
REQ-014 The FSM SHALL have two states: IDLE and COUNT.
REQ-015 IDLE->COUNT SHALL occur on the first cycle with ena=1 and clear=0; win_sel SHALL be sampled into a window-length register on that transition, and the window counter and spike count SHALL be zeroed.
REQ-016 COUNT->IDLE SHALL occur whenever ena=0; the partial window SHALL be discarded without a rate_valid pulse.
REQ-017 In COUNT, the window counter SHALL run 0..N-1, where N is the sampled length. Each cycle SHALL add 1 to the spike count on a spike event.
REQ-018 On the cycle where the window counter = N-1, rate SHALL load (count + event_this_cycle), and rate_valid SHALL pulse on the following cycle, aligned with the new rate value.
REQ-019 On that same terminal cycle, the next window SHALL begin with no gap: counter 0, count 0, and win_sel re-sampled. Changes to win_sel mid-window SHALL be ignored until then.
REQ-020 The spike count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-021 clear=1 in COUNT SHALL zero the window counter, spike count and ISI state, re-sample win_sel and stay in COUNT. clear SHALL take priority over a terminal-cycle rate load, so no rate_valid is produced.
REQ-022 clear=1 in IDLE SHALL hold IDLE.
REQ-023 ena=0 SHALL take priority over clear.
REQ-024 rate and isi SHALL hold their last values in IDLE and across clear.
REQ-025 busy SHALL equal (state==COUNT).

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE and clear all counters and the previous-spike register. It SHALL also set rate=0, rate_valid=0, isi=0, isi_valid=0 and busy=0.
REQ-027 Reset deasserted mid-window SHALL resume from IDLE; no partial result SHALL be reported.

Configuration
REQ-028 Macro SPIKE_RATE_ISI_EN, when defined, SHALL compile in ISI measurement, as follows:
- an ISI counter SHALL start at the first spike event after entering COUNT or after clear, and increment every cycle, saturating at 2^CNT_W-1;
- on each later event, isi SHALL load the counter value, isi_valid SHALL pulse on the next cycle, and the counter SHALL restart at 1;
- the first event after entering COUNT or after clear SHALL NOT pulse isi_valid;
- ISI measurement SHALL continue across window boundaries.
REQ-029 Without SPIKE_RATE_ISI_EN, isi and isi_valid SHALL be constant 0 and no ISI registers SHALL exist.

Verification
REQ-030 Reset with rst_n=0 while spike toggles -> all outputs 0, busy=0.
REQ-031 ena=1, win_sel=0, spike rising edge every 4 cycles -> rate=4 with a one-cycle rate_valid every 16 cycles, back-to-back, busy=1 throughout.
REQ-032 win_sel=3, spike held high for 128 cycles after a low cycle -> rate=1.
REQ-033 win_sel switched 0->1 mid-window -> current window ends after 16 cycles, next window after 32 cycles.
REQ-034 clear asserted on the terminal cycle with 3 events counted -> no rate_valid, rate unchanged, new 16-cycle window starts.
REQ-035 SPIKE_RATE_ISI_EN defined, events at cycles 10, 17, 30 after arming -> isi_valid pulses with isi=7 then isi=13, and no pulse for the first event. Without the macro -> isi and isi_valid stay 0.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spike rising edges over a 16/32/64/128-cycle window and reports the rate.
// Optional inter-spike-interval measurement is compiled in with SPIKE_RATE_ISI_EN.
//
// state | meaning
// IDLE  | decoder disarmed, outputs hold last results
// COUNT | window timer running, spike events accumulate
module spike_rate_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             spike,
   input  logic [1:0]       win_sel,
   input  logic             clear,
   output logic [CNT_W-1:0] rate,
   output logic             rate_valid,
   output logic [CNT_W-1:0] isi,
   output logic             isi_valid,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             spike_prev_q;
   logic [6:0]       win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic             rate_valid_q, rate_valid_d;
   logic             spike_evt;
   logic             win_tc;

   // Window timer counts down from N-1; the window length lives in the load value.
   function automatic logic [6:0] win_load(input logic [1:0] sel);
      case (sel)
         2'd0:    return 7'd15;
         2'd1:    return 7'd31;
         2'd2:    return 7'd63;
         default: return 7'd127;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
      return (inc && (cnt != CNT_MAX)) ? cnt + CNT_ONE : cnt;
   endfunction

   assign spike_evt = spike & ~spike_prev_q;
   assign win_tc    = (win_cnt_q == 7'd0);

   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      spk_cnt_d    = spk_cnt_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ena && !clear) begin
               state_d   = COUNT;
               win_cnt_d = win_load(win_sel);
               spk_cnt_d = '0;
            end
         end
         COUNT: begin
            if (!ena) begin
               state_d   = IDLE;
               win_cnt_d = '0;
               spk_cnt_d = '0;
            end else if (clear) begin
               win_cnt_d = win_load(win_sel);
               spk_cnt_d = '0;
            end else if (win_tc) begin
               rate_d       = sat_inc(spk_cnt_q, spike_evt);
               rate_valid_d = 1'b1;
               win_cnt_d    = win_load(win_sel);
               spk_cnt_d    = '0;
            end else begin
               win_cnt_d = win_cnt_q - 7'd1;
               spk_cnt_d = sat_inc(spk_cnt_q, spike_evt);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         spike_prev_q <= 1'b0;
         win_cnt_q    <= '0;
         spk_cnt_q    <= '0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         spike_prev_q <= spike;
         win_cnt_q    <= win_cnt_d;
         spk_cnt_q    <= spk_cnt_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = rate_valid_q;
   assign busy       = (state_q == COUNT);

`ifdef SPIKE_RATE_ISI_EN
   logic             isi_run_q, isi_run_d;
   logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
   logic [CNT_W-1:0] isi_q, isi_d;
   logic             isi_valid_q, isi_valid_d;

   // The interval counter is untouched by window boundaries; only arming, clear and disarm reset it.
   always_comb begin
      isi_run_d   = isi_run_q;
      isi_cnt_d   = isi_cnt_q;
      isi_d       = isi_q;
      isi_valid_d = 1'b0;
      if ((state_q != COUNT) || !ena || clear) begin
         isi_run_d = 1'b0;
         isi_cnt_d = '0;
      end else if (spike_evt) begin
         if (isi_run_q) begin
            isi_d       = isi_cnt_q;
            isi_valid_d = 1'b1;
         end
         isi_run_d = 1'b1;
         isi_cnt_d = CNT_ONE;
      end else if (isi_run_q) begin
         isi_cnt_d = sat_inc(isi_cnt_q, 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_run_q   <= 1'b0;
         isi_cnt_q   <= '0;
         isi_q       <= '0;
         isi_valid_q <= 1'b0;
      end else begin
         isi_run_q   <= isi_run_d;
         isi_cnt_q   <= isi_cnt_d;
         isi_q       <= isi_d;
         isi_valid_q <= isi_valid_d;
      end
   end

   assign isi       = isi_q;
   assign isi_valid = isi_valid_q;
`else
   assign isi       = '0;
   assign isi_valid = 1'b0;
`endif

endmodule
